ac2_wr_arbiter: RTL and testbench
=================================

// Module: ac2_wr_arbiter
// PURPOSE
//  Sequences the 4:1 accumulator write-back mux (sel_w_en[1:0]) feeding the partial-sum register.
//  Four partial-sum sources request the single register write port. This block grants them round-robin,
//  with bounded bursts, and drives the mux select plus the register write enable.
//  Sits between the MAC lanes and the accumulator register in the DP_1x64 datapath.
// PARAMETERS
//  BURST_MAX  4   max write beats per grant before forced release (>=1)
//  CNT_W      16  width of each per-requester beat counter (stats option only)
// PORTS
//  clk        in   1        clock; all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  req        in   4        req[i]=1: source i has a beat ready; held until granted beat taken
//  last       in   4        last[i]=1 with req[i]: this beat ends source i's transfer
//  hold       in   1        accumulator register busy; no write this cycle
//  gnt        out  4        one-hot grant, registered; 0 when idle
//  sel_w_en   out  2        mux select = index of granted source, registered
//  wr_en      out  1        register write strobe; a beat transfers when wr_en=1
//  busy       out  1        1 while a grant is active
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, sel_w_en=2'b00, wr_en=0, busy=0, rr_ptr=0, beat_cnt=0.
//  FSM: IDLE, GRANT.
//  IDLE:
//   - If req!=0, pick winner w by rotating priority starting at rr_ptr.
//   - Next cycle: GRANT, gnt=1<<w, sel_w_en=w, beat_cnt=0.
//   - hold does not block arbitration.
//  GRANT, owner w:
//   - wr_en = req[w] & ~hold (combinational from registered gnt).
//   - Each wr_en beat increments beat_cnt.
//   - Release when wr_en & (last[w] | beat_cnt==BURST_MAX-1).
//   - Also release when req[w]=0 (no beat that cycle).
//   - On release: rr_ptr=w+1 mod 4, so w has lowest priority next.
//   - Re-arbitrate in the release cycle over req, masking req[w] only on a last[w] release.
//   - If a winner exists: back-to-back GRANT next cycle with the new gnt/sel_w_en, zero idle gap.
//   - Otherwise go to IDLE.
//  hold=1 in GRANT: no beat, beat_cnt frozen, grant kept; hold never forces release.
//  sel_w_en keeps its last value in IDLE so the mux output stays stable; only gnt clears.
//  Latency: first request to first wr_en = 1 cycle minimum (req at t, wr_en at t+1).
//  Simultaneous req from all 4 sources, each with last on every beat: grants w, w+1, w+2, w+3,
//   one beat per cycle, 100% write-port utilisation.
//  Reset asserted mid-burst: immediate return to the reset values. Interrupted beats are not
//   replayed; sources must re-request.
//  Invariants: gnt is one-hot or zero; wr_en -> gnt!=0; sel_w_en==onehot2idx(gnt) whenever busy.
// CONFIGURATION
//  AC2_ARB_STATS_EN defined:
//   - Adds input stats_clr (1) and output beat_cnt_o (4*CNT_W).
//   - beat_cnt_o[i*CNT_W+:CNT_W] counts wr_en beats of source i.
//   - Counters saturate at all-ones, are cleared by reset, and clear synchronously on stats_clr.
//   - stats_clr has priority over a same-cycle beat.
//  AC2_ARB_STATS_EN undefined: those ports and counters do not exist; the arbitration function is identical.
// STRUCTURE
//  ac2_pkg:
//   - localparams NREQ=4, SEL_W=2.
//   - typedef enum logic {IDLE, GRANT} ac2_arb_state_t.
//   - function onehot2idx.
//  Sub-module ac2_rr_pick (combinational):
//   - Inputs: req[3:0], ptr[1:0].
//   - Outputs: found, idx[1:0].
//   - Rotate, priority-encode, un-rotate.
//  Top holds the FSM, rr_ptr, beat_cnt and the optional stats counters.
// TESTING
//  1 Reset, req=0100 at t0, last=0100 -> t1: gnt=0100, sel_w_en=2, wr_en=1; t2: gnt=0, sel_w_en stays 2.
//  2 req=1111 held, last=1111 always -> grants 0,1,2,3,0 on consecutive cycles; wr_en=1 every cycle.
//  3 req=0001 held, last=0, BURST_MAX=4 -> 4 beats then release. With only req0 pending:
//    one idle-free re-grant to 0, beats continue.
//  4 Burst on src1 with hold=1 for 3 cycles mid-burst -> wr_en=0 and beat_cnt frozen;
//    after hold the remaining beats complete, total 4.
//  5 Reset asserted during beat 2 of a burst -> same cycle: gnt=0, wr_en=0, busy=0;
//    after release, sel_w_en=0 and rr_ptr=0.
//  6 AC2_ARB_STATS_EN, scenario 2 for 8 cycles -> beat_cnt_o = 2 per source;
//    stats_clr pulse -> all 0 next cycle.

Source files
------------

// File: rtl/ac2_pkg.sv
// ----------------------------------------------------------------------------
// ac2_pkg
//   Shared definitions for the accumulator write-back arbiter.
//   NREQ             number of partial-sum sources competing for the write port
//   SEL_W            width of the write-back mux select
//   ac2_arb_state_t  arbiter FSM state (IDLE, GRANT)
//   onehot2idx()     converts a one-hot grant vector to the source index
// ----------------------------------------------------------------------------
package ac2_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } ac2_arb_state_t;

    // OR-reduction style encoder: exact for one-hot input, returns 0 for zero input.
    function automatic logic [SEL_W-1:0] onehot2idx(input logic [NREQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = idx | SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ac2_rr_pick.sv
// ----------------------------------------------------------------------------
// ac2_rr_pick
//   Combinational round-robin picker. Priority starts at source 'ptr' and
//   rotates upward (ptr, ptr+1, ... wrapping mod NREQ).
// Ports
//   req    in   NREQ   request vector
//   ptr    in   SEL_W  index holding highest priority
//   found  out  1      at least one request present
//   idx    out  SEL_W  index of the winning source (valid when found=1)
// ----------------------------------------------------------------------------
module ac2_rr_pick
    import ac2_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [SEL_W-1:0]  offset;

    // Rotate so that source 'ptr' lands at bit 0, pick the lowest set bit,
    // then add ptr back; the SEL_W-bit add wraps naturally mod NREQ.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[NREQ-1:0];
        offset  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) offset = SEL_W'(i);
        end
        found = |req;
        idx   = offset + ptr;
    end

endmodule

// File: rtl/ac2_wr_arbiter.sv
// ----------------------------------------------------------------------------
// ac2_wr_arbiter
//   Round-robin arbiter with bounded bursts for the single write port of the
//   partial-sum register. Drives the 4:1 write-back mux select and the
//   register write strobe.
// Parameters
//   BURST_MAX  max write beats per grant before forced release (>=1)
//   CNT_W      width of each per-source beat counter (statistics build only)
// Ports
//   clk         in   1        clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   req         in   4        source i has a beat ready
//   last        in   4        with req[i]: this beat ends source i's transfer
//   hold        in   1        register busy, no write this cycle
//   gnt         out  4        registered one-hot grant, 0 when idle
//   sel_w_en    out  2        registered mux select (index of granted source)
//   wr_en       out  1        write strobe; a beat transfers when 1
//   busy        out  1        a grant is active
//   stats_clr   in   1        (AC2_ARB_STATS_EN) synchronous clear of beat counters
//   beat_cnt_o  out  4*CNT_W  (AC2_ARB_STATS_EN) saturating beat count per source
// Build option
//   AC2_ARB_STATS_EN  adds the per-source beat counters and their ports.
// ----------------------------------------------------------------------------
module ac2_wr_arbiter
    import ac2_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    last,
    input  logic               hold,
    output logic [NREQ-1:0]    gnt,
    output logic [SEL_W-1:0]   sel_w_en,
    output logic               wr_en,
    output logic               busy
`ifdef AC2_ARB_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [NREQ*CNT_W-1:0] beat_cnt_o
`endif
);

    localparam int              BC_W      = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BURST_MAX - 1);

    ac2_arb_state_t   state_q, state_d;
    logic [NREQ-1:0]  gnt_d;
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [SEL_W-1:0] owner;
    logic             owner_req;
    logic             owner_last;
    logic             release_now;
    logic [NREQ-1:0]  pick_req;
    logic [SEL_W-1:0] pick_ptr;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    // Current owner decoded from the registered grant.
    assign owner      = onehot2idx(gnt);
    assign owner_req  = |(req & gnt);
    assign owner_last = |(last & gnt);

    // Release on a finishing beat (last or burst limit) or when the owner
    // stops requesting. hold alone never releases since owner_req stays high.
    assign release_now = busy & ((wr_en & (owner_last | (beat_cnt_q == BEAT_LAST))) | ~owner_req);

    // While releasing, re-arbitrate with the owner at lowest priority; its
    // request is masked only when it just signalled last.
    assign pick_req = release_now ? (req & ~((wr_en & owner_last) ? gnt : '0)) : req;
    assign pick_ptr = release_now ? owner + SEL_W'(1) : rr_ptr_q;

    ac2_rr_pick u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt        <= '0;
            sel_w_en   <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            gnt        <= gnt_d;
            sel_w_en   <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt;
        sel_d      = sel_w_en;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    gnt_d      = NREQ'(1) << pick_idx;
                    sel_d      = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (wr_en) beat_cnt_d = beat_cnt_q + BC_W'(1);
                if (release_now) begin
                    rr_ptr_d   = owner + SEL_W'(1);
                    beat_cnt_d = '0;
                    if (pick_found) begin
                        gnt_d = NREQ'(1) << pick_idx;
                        sel_d = pick_idx;
                    end else begin
                        // sel_w_en keeps its value so the mux output stays stable.
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        busy  = (state_q == GRANT);
        wr_en = busy & owner_req & ~hold;
    end

`ifdef AC2_ARB_STATS_EN
    logic [CNT_W-1:0] stat_q [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is reset explicitly; zero counts after reset are part of its contract.
            for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (stats_clr) begin
                    stat_q[i] <= '0;
                end else if (wr_en && gnt[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        beat_cnt_o = '0;
        for (int i = 0; i < NREQ; i++) beat_cnt_o[i*CNT_W +: CNT_W] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_ac2_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ac2_wr_arbiter
//   Directed bench for ac2_wr_arbiter. Each step drives one cycle of inputs
//   and checks the outputs against hand-derived values; every expected write
//   beat is queued with its source index and popped when wr_en appears.
// ----------------------------------------------------------------------------
module tb_ac2_wr_arbiter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = '0;
    logic [3:0] last  = '0;
    logic       hold  = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel_w_en;
    logic       wr_en;
    logic       busy;
`ifdef AC2_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [63:0] beat_cnt_o;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [1:0] beat_q [$];
    logic [1:0] beat_exp;

    ac2_wr_arbiter #(.BURST_MAX(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .last       (last),
        .hold       (hold),
        .gnt        (gnt),
        .sel_w_en   (sel_w_en),
        .wr_en      (wr_en),
        .busy       (busy)
`ifdef AC2_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .beat_cnt_o (beat_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, check just after that.
    task automatic step(input string tag, input logic rst_v,
                        input logic [3:0] r, input logic [3:0] l, input logic h,
                        input logic [3:0] eg, input logic [1:0] es,
                        input logic ew, input logic eb);
        @(posedge clk);
        #1;
        rst_n = rst_v;
        req   = r;
        last  = l;
        hold  = h;
        if (ew) beat_q.push_back(es);
        #1;
        check({tag, ".gnt"},   32'(gnt),      32'(eg));
        check({tag, ".sel"},   32'(sel_w_en), 32'(es));
        check({tag, ".wr_en"}, 32'(wr_en),    32'(ew));
        check({tag, ".busy"},  32'(busy),     32'(eb));
    endtask

    // Beat scoreboard: each write strobe must match the next queued source.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            beat_exp = (beat_q.size() > 0) ? beat_q.pop_front() : 2'bxx;
            check("beat.src", 32'(sel_w_en), 32'(beat_exp));
        end
    end

    initial begin
        // Reset values.
        #12;
        check("rst.gnt",   32'(gnt),      32'h0);
        check("rst.sel",   32'(sel_w_en), 32'h0);
        check("rst.wr_en", 32'(wr_en),    32'h0);
        check("rst.busy",  32'(busy),     32'h0);

        // Single request with last: one-cycle latency, sel holds in IDLE.
        step("t1.c0", 1, 4'b0100, 4'b0100, 0, 4'b0000, 2'd0, 0, 0);
        step("t1.c1", 1, 4'b0100, 4'b0100, 0, 4'b0100, 2'd2, 1, 1);
        step("t1.c2", 1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd2, 0, 0);

        // Source 0 alone, no last: 4-beat burst, gapless re-grant, then drop.
        step("t3.c0", 1, 4'b0001, 4'b0000, 0, 4'b0000, 2'd2, 0, 0);
        step("t3.c1", 1, 4'b0001, 4'b0000, 0, 4'b0001, 2'd0, 1, 1);
        step("t3.c2", 1, 4'b0001, 4'b0000, 0, 4'b0001, 2'd0, 1, 1);
        step("t3.c3", 1, 4'b0001, 4'b0000, 0, 4'b0001, 2'd0, 1, 1);
        step("t3.c4", 1, 4'b0001, 4'b0000, 0, 4'b0001, 2'd0, 1, 1);
        step("t3.c5", 1, 4'b0001, 4'b0000, 0, 4'b0001, 2'd0, 1, 1);
        step("t3.c6", 1, 4'b0001, 4'b0000, 0, 4'b0001, 2'd0, 1, 1);
        step("t3.c7", 1, 4'b0000, 4'b0000, 0, 4'b0001, 2'd0, 0, 1);

        // Source 1 burst with 3 hold cycles after beat 2; release after beat 4
        // hands over to source 2, whose last re-grants source 1.
        step("t4.d0", 1, 4'b0010, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        step("t4.d1", 1, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 1, 1);
        step("t4.d2", 1, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 1, 1);
        step("t4.d3", 1, 4'b0010, 4'b0000, 1, 4'b0010, 2'd1, 0, 1);
        step("t4.d4", 1, 4'b0010, 4'b0000, 1, 4'b0010, 2'd1, 0, 1);
        step("t4.d5", 1, 4'b0010, 4'b0000, 1, 4'b0010, 2'd1, 0, 1);
        step("t4.d6", 1, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 1, 1);
        step("t4.d7", 1, 4'b0110, 4'b0000, 0, 4'b0010, 2'd1, 1, 1);
        step("t4.d8", 1, 4'b0110, 4'b0100, 0, 4'b0100, 2'd2, 1, 1);
        step("t4.d9", 1, 4'b0010, 4'b0010, 0, 4'b0010, 2'd1, 1, 1);
        step("t4.d10", 1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd1, 0, 0);

        // Reset during beat 2 of a source-3 burst clears outputs immediately.
        step("t5.e0", 1, 4'b1000, 4'b0000, 0, 4'b0000, 2'd1, 0, 0);
        step("t5.e1", 1, 4'b1000, 4'b0000, 0, 4'b1000, 2'd3, 1, 1);
        step("t5.e2", 0, 4'b1000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        step("t5.e3", 0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        step("t5.e4", 1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        // All four requesting with last on every beat: rotation starts at 0
        // (pointer reset), one beat per cycle with no gaps.
        step("t2.f0", 1, 4'b1111, 4'b1111, 0, 4'b0000, 2'd0, 0, 0);
        step("t2.f1", 1, 4'b1111, 4'b1111, 0, 4'b0001, 2'd0, 1, 1);
        step("t2.f2", 1, 4'b1111, 4'b1111, 0, 4'b0010, 2'd1, 1, 1);
        step("t2.f3", 1, 4'b1111, 4'b1111, 0, 4'b0100, 2'd2, 1, 1);
        step("t2.f4", 1, 4'b1111, 4'b1111, 0, 4'b1000, 2'd3, 1, 1);
        step("t2.f5", 1, 4'b1111, 4'b1111, 0, 4'b0001, 2'd0, 1, 1);
        step("t2.f6", 1, 4'b1111, 4'b1111, 0, 4'b0010, 2'd1, 1, 1);
        step("t2.f7", 1, 4'b1111, 4'b1111, 0, 4'b0100, 2'd2, 1, 1);
        step("t2.f8", 1, 4'b1111, 4'b1111, 0, 4'b1000, 2'd3, 1, 1);
        step("t2.f9", 1, 4'b0000, 4'b0000, 0, 4'b0001, 2'd0, 0, 1);
`ifdef AC2_ARB_STATS_EN
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6.cnt%0d", i), 32'(beat_cnt_o[i*16 +: 16]), 32'd2);
        end
        stats_clr = 1'b1;
`endif
        step("t2.f10", 1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
`ifdef AC2_ARB_STATS_EN
        stats_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6.clr%0d", i), 32'(beat_cnt_o[i*16 +: 16]), 32'd0);
        end
`endif

        // Every queued beat must have been observed.
        @(negedge clk);
        check("beat.drain", 32'(beat_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
